// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and the ALU control unit.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        ALU_RTYPE = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_SLT   = 3'b110,
        ALU_SLTU  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_src_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_ITYPE   = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_idec.sv
// Combinational opcode decode: instruction class plus the ALU op for I-type ALU instructions.
module multicycle_ctrl_idec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   i_opcode,
    output instr_class_t o_class,
    output alu_op_t      o_alu_op
);

    // Map opcode to class; anything not recognised is illegal.
    always_comb begin
        o_class  = CLS_ILLEGAL;
        o_alu_op = ALU_ADD;
        case (i_opcode)
            OP_RTYPE:      o_class = CLS_RTYPE;
            OP_LW, OP_SW:  o_class = CLS_MEM;
            OP_BEQ, OP_BNE: o_class = CLS_BRANCH;
            OP_J:          o_class = CLS_JUMP;
            OP_ADDI:  begin o_class = CLS_ITYPE; o_alu_op = ALU_ADD;  end
            OP_ANDI:  begin o_class = CLS_ITYPE; o_alu_op = ALU_AND;  end
            OP_ORI:   begin o_class = CLS_ITYPE; o_alu_op = ALU_OR;   end
            OP_XORI:  begin o_class = CLS_ITYPE; o_alu_op = ALU_XOR;  end
            OP_SLTI:  begin o_class = CLS_ITYPE; o_alu_op = ALU_SLT;  end
            OP_SLTIU: begin o_class = CLS_ITYPE; o_alu_op = ALU_SLTU; end
            default:  begin o_class = CLS_ILLEGAL; o_alu_op = ALU_ADD; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle datapath controller.
//
// state    | meaning
// ---------+-------------------------------------------------------
// FETCH    | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE   | latch opcode, precompute branch target into ALUOut
// MEM_ADDR | compute rs + imm for LW/SW
// MEM_RD   | load data read, wait for mem_ready
// MEM_WB   | write loaded data into rt
// MEM_WR   | store data write, wait for mem_ready
// EXEC_R   | R-type ALU operation rs op rt
// EXEC_I   | I-type ALU operation rs op imm
// ALU_WB   | write ALUOut into rd (R-type) or rt (I-type)
// BRANCH   | compare rs/rt, load PC from ALUOut if taken
// JUMP     | load PC from jump target
// HALT     | illegal opcode seen; exits only through reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       halted
);

    state_t       r_state;
    state_t       w_next;
    logic [5:0]   r_opcode;
    logic [5:0]   w_dec_opcode;
    instr_class_t w_class;
    alu_op_t      w_ialu_op;
    logic         w_fetch_done;

    // The live opcode is only meaningful in DECODE; later states use the latched copy.
    assign w_dec_opcode = (r_state == S_DECODE) ? opcode : r_opcode;

    // Strobes from a completed fetch are blocked while reset is held.
    assign w_fetch_done = mem_ready & rst_n;

    multicycle_ctrl_idec u_idec (
        .i_opcode (w_dec_opcode),
        .o_class  (w_class),
        .o_alu_op (w_ialu_op)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Opcode latch, captured while in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_opcode <= 6'h00;
        else if (r_state == S_DECODE)  r_opcode <= opcode;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_class)
                    CLS_RTYPE:  w_next = S_EXEC_R;
                    CLS_MEM:    w_next = S_MEM_ADDR;
                    CLS_BRANCH: w_next = S_BRANCH;
                    CLS_JUMP:   w_next = S_JUMP;
                    CLS_ITYPE:  w_next = S_EXEC_I;
                    default:    w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_ADDR: w_next = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   w_next = S_ALU_WB;
            S_EXEC_I:   w_next = S_ALU_WB;
            S_ALU_WB:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // Output decode; Moore except the fetch completion strobes and the branch PC load.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_RTYPE;
        pc_src     = PCSRC_ALU;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (w_fetch_done) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = w_ialu_op;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                reg_dst = (w_class == CLS_RTYPE);
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_we     = (r_opcode == OP_BNE) ? ~alu_zero : alu_zero;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_we  = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule
